dff_bank_arbiter: RTL and testbench
===================================

# dff_bank_arbiter

Round-robin access controller for a small bank of D flip-flop registers shared by several requesters. Each requester issues a single read or write through a req/gnt handshake, and the block serialises these accesses into the bank. The full bank contents are also exposed as a flat `q` bus for downstream logic. It sits between the requester-side control logic and the storage flops, and it is the only writer of the bank.

## Interface
- `NREQ`, 4: number of requesters, 2..8
- `WIDTH`, 8: register width in bits
- `DEPTH`, 4: number of registers; power of two, >= 2
- `AW`, $clog2(DEPTH): address width (derived; do not override)
- `LOCK_MAX`, 4: maximum consecutive locked grants; present only with `DFF_ARB_LOCK_EN`

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  NREQ  per-requester access request
- `we`  in  NREQ  per-requester write enable; 1 = write, 0 = read
- `addr`  in  NREQ*AW  per-requester address; requester i uses slice [i*AW +: AW]
- `wdata`  in  NREQ*WIDTH  per-requester write data; slice [i*WIDTH +: WIDTH]
- `lock`  in  NREQ  per-requester burst lock; present only with `DFF_ARB_LOCK_EN`
- `gnt`  out  NREQ  registered grant, one-hot or zero
- `rvalid`  out  1  read data valid, one-cycle pulse
- `rdata`  out  WIDTH  read data
- `rid`  out  $clog2(NREQ)  index of the requester that owns `rdata`
- `q`  out  DEPTH*WIDTH  bank contents; register k is at [k*WIDTH +: WIDTH]

## Operation
- States:
  - IDLE: no access in flight.
  - GRANT: the registered `gnt` is high for exactly one requester.
- Round-robin pointer `ptr`:
  - Reset value is 0.
  - Priority search runs `ptr`, `ptr+1`, … modulo NREQ.
  - After a grant to i, `ptr` becomes (i+1) mod NREQ, wrapping from NREQ-1 to 0.
- IDLE with any `req` high: `gnt` is set to the winner and the state moves to GRANT. IDLE with no `req` high: the block stays in IDLE.
- GRANT:
  - The winner must hold `req`, `we`, `addr` and `wdata` stable.
  - At the end of the GRANT cycle, a write commits `wdata` to the bank.
  - A read captures bank[`addr`] into `rdata`, sets `rid` to the winner and pulses `rvalid`.
  - The state then returns to IDLE and `gnt` goes to 0.
- A requester drops `req` the cycle after it sees `gnt`. If `req` is still high in IDLE, it is treated as a new request.
- Requests from non-winners are held pending. Requesters must not withdraw a pending request.
- Reset values:
  - `gnt` = 0, `rvalid` = 0, `rdata` = 0, `rid` = 0.
  - All bank registers, and therefore `q`, = 0.
  - State = IDLE, `ptr` = 0.
- Reset asserted mid-GRANT: the in-flight access is aborted. No write commits and no `rvalid` pulse is produced.

## Timing
- Request-to-grant latency: `req` sampled high in cycle t gives `gnt` high in cycle t+1.
- Writes: bank and `q` show the new value in t+2.
- Reads: `rvalid`, `rdata` and `rid` are valid in t+2, for one cycle only.
- Peak throughput is one access per 2 cycles (IDLE/GRANT alternation).
- `rvalid` and `gnt` may be high in the same cycle: the read from the previous grant coincides with a new grant.
- Read of a register in the same GRANT cycle in which it is written is not possible, since only one access is granted per cycle.

## Configuration
- `DFF_ARB_LOCK_EN` defined:
  - The `lock` port and `LOCK_MAX` parameter exist.
  - If the winner has `lock` high in its GRANT cycle and fewer than `LOCK_MAX` consecutive grants have been issued, the state stays in GRANT. `gnt` stays on the same requester, with one access per cycle, and `ptr` is not advanced.
  - The burst ends when `lock` is low, `req` is low, or `LOCK_MAX` is reached. The block then returns to IDLE and `ptr` advances.
  - The lock counter resets to 0 on every exit from GRANT.
- `DFF_ARB_LOCK_EN` undefined:
  - No `lock` port.
  - Every GRANT lasts exactly one cycle.

## Structure
- Package `dff_arb_pkg` contains:
  - the state enum (IDLE, GRANT);
  - a `next_rr` function: round-robin winner from `req` and `ptr`;
  - an `onehot_to_idx` function.
- One sub-module, `dff_reg_bank`:
  - DEPTH×WIDTH flops with asynchronous active-low clear;
  - single write port;
  - combinational read mux;
  - flat `q` output.
- Arbiter FSM, `ptr`, lock counter and read capture registers live in `dff_bank_arbiter`.

## Test plan
- Reset: hold `rst_n`=0 with `req`=4'hF → `gnt`=0, `rvalid`=0, `q`=0. Release reset → first grant goes to requester 0.
- Single write: requester 1 writes `addr`=2, `wdata`=8'hA5 → `gnt`=4'b0010 one cycle later. `q[23:16]`=8'hA5 one cycle after that.
- Fairness and wrap: all four `req` held high continuously, each dropping `req` one cycle after its grant and then re-raising it → grant order 0,1,2,3,0, two cycles apart.
- Read: after the write, requester 2 reads `addr`=2 → `rvalid` pulse with `rdata`=8'hA5, `rid`=2.
- Lock (`DFF_ARB_LOCK_EN`, `LOCK_MAX`=4): requester 0 holds `lock` and `req`, requester 1 also requests → 4 consecutive cycles of `gnt`=4'b0001, then IDLE, then `gnt`=4'b0010.
- Reset mid-grant: assert `rst_n`=0 during the GRANT cycle of a write of 8'h3C → bank stays 0 and no `rvalid` pulse appears.

Source files
------------

// File: rtl/dff_arb_pkg.sv
// Shared types and helpers for the dff_bank_arbiter block.
// Helpers work on 8-bit request vectors (NREQ <= 8); callers zero-extend.
package dff_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int MAX_REQ = 8;

    // Round-robin winner: first set bit of req searching ptr, ptr+1, ... mod n.
    // Returns a one-hot vector, or zero when no request is set.
    function automatic logic [MAX_REQ-1:0] next_rr(input logic [MAX_REQ-1:0] req,
                                                   input logic [2:0]         ptr,
                                                   input int                 n);
        logic [MAX_REQ-1:0] win;
        int                 idx;
        win = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && win == '0 && req[idx])
                win[idx] = 1'b1;
        end
        return win;
    endfunction

    // Index of the set bit in a one-hot vector (0 when zero).
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int k = 0; k < MAX_REQ; k++)
            if (oh[k])
                idx = 3'(k);
        return idx;
    endfunction

endpackage

// File: rtl/dff_reg_bank.sv
// DEPTH x WIDTH register bank: one write port, combinational read mux,
// whole contents exposed as a flat bus.
module dff_reg_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [AW-1:0]          addr,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [DEPTH*WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;

    // Storage flops, cleared asynchronously, written one entry at a time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem <= '0;
        else if (wr_en)
            mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
    // Packed layout already places entry k at [k*WIDTH +: WIDTH].
    assign q     = mem;

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin access controller in front of a small register bank.
// Optional burst lock is enabled by defining DFF_ARB_LOCK_EN.
module dff_bank_arbiter
    import dff_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
`ifdef DFF_ARB_LOCK_EN
    parameter int LOCK_MAX = 4,
`endif
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           we,
    input  logic [NREQ*AW-1:0]        addr,
    input  logic [NREQ*WIDTH-1:0]     wdata,
`ifdef DFF_ARB_LOCK_EN
    input  logic [NREQ-1:0]           lock,
`endif
    output logic [NREQ-1:0]           gnt,
    output logic                      rvalid,
    output logic [WIDTH-1:0]          rdata,
    output logic [$clog2(NREQ)-1:0]   rid,
    output logic [DEPTH*WIDTH-1:0]    q
);

    localparam int PW = $clog2(NREQ);

    arb_state_e       state, state_next;
    logic [PW-1:0]    ptr, ptr_next;
    logic [NREQ-1:0]  gnt_next;
    logic [PW-1:0]    g_idx;
    logic [MAX_REQ-1:0] req8, win8;
    logic             wr_en, rd_en;
    logic [AW-1:0]    cur_addr;
    logic [WIDTH-1:0] cur_wdata, bank_rdata;
    logic             stay;

    // Owner of the current grant and its request fields.
    always_comb begin
        req8      = '0;
        req8[NREQ-1:0] = req;
        win8      = next_rr(req8, 3'(ptr), NREQ);
        g_idx     = PW'(onehot_to_idx(8'(gnt)));
        cur_addr  = addr[int'(g_idx)*AW +: AW];
        cur_wdata = wdata[int'(g_idx)*WIDTH +: WIDTH];
    end

`ifdef DFF_ARB_LOCK_EN
    localparam int LCW = $clog2(LOCK_MAX + 1);
    logic [LCW-1:0] lock_cnt;

    // Keep the grant while the owner locks and the burst limit is not reached.
    assign stay = lock[g_idx] && req[g_idx] && (int'(lock_cnt) + 1 < LOCK_MAX);

    // Consecutive-grant counter; cleared on every exit from GRANT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lock_cnt <= '0;
        else if (state == GRANT && stay)
            lock_cnt <= lock_cnt + 1'b1;
        else
            lock_cnt <= '0;
    end
`else
    assign stay = 1'b0;
`endif

    // Next-state, grant and access strobes.
    always_comb begin
        state_next = state;
        gnt_next   = gnt;
        ptr_next   = ptr;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    gnt_next   = win8[NREQ-1:0];
                    state_next = GRANT;
                end
            end
            GRANT: begin
                wr_en = we[g_idx];
                rd_en = !we[g_idx];
                if (!stay) begin
                    gnt_next   = '0;
                    state_next = IDLE;
                    ptr_next   = (g_idx == PW'(NREQ - 1)) ? '0 : g_idx + 1'b1;
                end
            end
            default: begin
                gnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // FSM, grant and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_next;
            gnt   <= gnt_next;
            ptr   <= ptr_next;
        end
    end

    // Read capture: one-cycle rvalid, rdata/rid hold until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rid    <= '0;
        end else begin
            rvalid <= rd_en;
            if (rd_en) begin
                rdata <= bank_rdata;
                rid   <= g_idx;
            end
        end
    end

    dff_reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wr_en),
        .addr  (cur_addr),
        .wdata (cur_wdata),
        .rdata (bank_rdata),
        .q     (q)
    );

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter (NREQ=4, WIDTH=8, DEPTH=4).
// Lock steps are included only when DFF_ARB_LOCK_EN is defined.
module tb_dff_bank_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req, we;
    logic [7:0]  addr;
    logic [31:0] wdata;
`ifdef DFF_ARB_LOCK_EN
    logic [3:0]  lock;
`endif
    logic [3:0]  gnt;
    logic        rvalid;
    logic [7:0]  rdata;
    logic [1:0]  rid;
    logic [31:0] q;

    int errors = 0;
    int checks = 0;

    dff_bank_arbiter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
`ifdef DFF_ARB_LOCK_EN
        .lock   (lock),
`endif
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata),
        .rid    (rid),
        .q      (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'hF;
        we    = 4'h0;
        addr  = 8'h00;
        wdata = 32'h0;
`ifdef DFF_ARB_LOCK_EN
        lock  = 4'h0;
`endif
        // Reset held with all requests high
        tick(); tick();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_rid", 32'(rid), 32'h0);
        check("rst_q", q, 32'h0);

        // Release: all requests held, grants go 0,1,2,3,0 two cycles apart
        rst_n = 1'b1;
        tick(); check("rr_g0", 32'(gnt), 32'h1);
        tick(); check("rr_idle0", 32'(gnt), 32'h0);
        check("rr_rvalid0", 32'(rvalid), 32'h1);
        check("rr_rid0", 32'(rid), 32'h0);
        tick(); check("rr_g1", 32'(gnt), 32'h2);
        tick(); check("rr_idle1", 32'(gnt), 32'h0);
        check("rr_rid1", 32'(rid), 32'h1);
        tick(); check("rr_g2", 32'(gnt), 32'h4);
        tick(); check("rr_idle2", 32'(gnt), 32'h0);
        tick(); check("rr_g3", 32'(gnt), 32'h8);
        tick(); check("rr_idle3", 32'(gnt), 32'h0);
        check("rr_rid3", 32'(rid), 32'h3);
        tick(); check("rr_wrap", 32'(gnt), 32'h1);
        req = 4'h0;
        tick(); check("rr_end", 32'(gnt), 32'h0);

        // Requester 1 writes A5 to register 2
        req = 4'b0010; we = 4'b0010; addr = 8'b0000_1000; wdata = 32'h0000_A500;
        tick(); check("wr_gnt", 32'(gnt), 32'h2);
        check("wr_rvalid_grant", 32'(rvalid), 32'h0);
        tick(); check("wr_q", q, 32'h00A5_0000);
        check("wr_gnt_off", 32'(gnt), 32'h0);
        check("wr_no_rvalid", 32'(rvalid), 32'h0);
        req = 4'h0; we = 4'h0;

        // Requester 2 reads register 2
        req = 4'b0100; addr = 8'b0010_0000;
        tick(); check("rd_gnt", 32'(gnt), 32'h4);
        tick(); check("rd_rvalid", 32'(rvalid), 32'h1);
        check("rd_rdata", 32'(rdata), 32'hA5);
        check("rd_rid", 32'(rid), 32'h2);
        req = 4'h0;
        tick(); check("rd_pulse", 32'(rvalid), 32'h0);
        check("rd_rdata_hold", 32'(rdata), 32'hA5);

`ifdef DFF_ARB_LOCK_EN
        // Requester 0 locks a burst while requester 1 waits
        req = 4'b0011; lock = 4'b0001; addr = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tick(); check("lock_burst", 32'(gnt), 32'h1);
        end
        tick(); check("lock_exit", 32'(gnt), 32'h0);
        req = 4'b0010; lock = 4'h0;
        tick(); check("lock_next", 32'(gnt), 32'h2);
        req = 4'h0;
        tick(); check("lock_done", 32'(gnt), 32'h0);
`endif

        // Reset during the grant cycle of a write of 3C
        req = 4'b0001; we = 4'b0001; addr = 8'h01; wdata = 32'h0000_003C;
        tick(); check("abort_gnt", 32'(gnt), 32'h1);
        #2 rst_n = 1'b0;
        #1 check("abort_gnt_async", 32'(gnt), 32'h0);
        tick(); check("abort_q", q, 32'h0);
        check("abort_rvalid", 32'(rvalid), 32'h0);
        check("abort_gnt_held", 32'(gnt), 32'h0);
        req = 4'h0; we = 4'h0;
        rst_n = 1'b1;
        tick(); check("abort_after", 32'(rvalid), 32'h0);
        check("abort_q_after", q, 32'h0);

        // After reset the pointer restarts at 0; lone requester 3 still wins
        req = 4'b1000; we = 4'b1000; addr = 8'hC0; wdata = 32'h5A00_0000;
        tick(); check("post_gnt", 32'(gnt), 32'h8);
        tick(); check("post_q", q, 32'h5A00_0000);
        req = 4'h0; we = 4'h0;
        tick(); check("post_idle", 32'(gnt), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
